// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared encodings for the pipeline hazard/stall controller.
// Control inputs from the decode pipe are active-low; CTL_ON is their asserted level.
package hazard_stall_ctrl_pkg;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_MULTI = 1'b1
   } state_t;

   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam logic       CTL_ON   = 1'b0;

endpackage

// File: rtl/hazard_match.sv
// Producer-vs-consumer register comparator; register 0 never matches.
// Purely combinational, 0 cycles; no flow control.
module hazard_match
   import hazard_stall_ctrl_pkg::*;
(
   input  logic [4:0] dst,
   input  logic [4:0] rs,
   input  logic [4:0] rt,
   input  logic       use_rt,
   output logic       hit
);

   assign hit = (dst != REG_ZERO) && ((dst == rs) || (use_rt && (dst == rt)));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/bubble/flush control for load-use, ID-branch and multi-cycle EX hazards.
// Latency 0 cycles hazard-to-stall; stalls hold the front end, EX hold freezes ID/EX.
module hazard_stall_ctrl
   import hazard_stall_ctrl_pkg::*;
#(
   parameter int MUL_CYCLES = 4,
   parameter int CNT_W      = 8,
   parameter int STAT_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [4:0]        if_id_rs,
   input  logic [4:0]        if_id_rt,
   input  logic              if_id_use_rt,
   input  logic              id_branch,
   input  logic              br_taken,
   input  logic [4:0]        id_ex_dst,
   input  logic              id_ex_regwrite,
   input  logic              id_ex_memread,
   input  logic [4:0]        ex_mem_dst,
   input  logic              ex_mem_memread,
   input  logic              ex_multi_start,
   output logic              pc_write,
   output logic              if_id_write,
   output logic              id_ex_bubble,
   output logic              if_id_flush,
   output logic              ex_hold,
   output logic              multi_done,
   output logic [STAT_W-1:0] stall_cnt
);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             hit_ld, hit_br_ex, hit_br_mem;
   logic             load_use, br_ex, br_ld_mem, haz, front_stall;

   hazard_match u_match_ld (
      .dst(id_ex_dst), .rs(if_id_rs), .rt(if_id_rt), .use_rt(if_id_use_rt), .hit(hit_ld)
   );
   hazard_match u_match_br_ex (
      .dst(id_ex_dst), .rs(if_id_rs), .rt(if_id_rt), .use_rt(if_id_use_rt), .hit(hit_br_ex)
   );
   hazard_match u_match_br_mem (
      .dst(ex_mem_dst), .rs(if_id_rs), .rt(if_id_rt), .use_rt(if_id_use_rt), .hit(hit_br_mem)
   );

   assign load_use  = (id_ex_memread == CTL_ON) && hit_ld;
   assign br_ex     = id_branch && (id_ex_regwrite == CTL_ON) && hit_br_ex;
   assign br_ld_mem = id_branch && (ex_mem_memread == CTL_ON) && hit_br_mem;
   assign haz       = load_use | br_ex | br_ld_mem;

   // The start cycle counts toward occupancy, so MULTI runs MUL_CYCLES-1 cycles.
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      ex_hold    = 1'b0;
      multi_done = 1'b0;
      case (state)
         ST_RUN: begin
            if (ex_multi_start) begin
               ex_hold   = 1'b1;
               state_nxt = ST_MULTI;
               cnt_nxt   = CNT_W'(MUL_CYCLES - 2);
            end
         end
         ST_MULTI: begin
            if (cnt != '0) begin
               ex_hold = 1'b1;
               cnt_nxt = cnt - 1'b1;
            end else begin
               multi_done = 1'b1;
               state_nxt  = ST_RUN;
            end
         end
         default: state_nxt = ST_RUN;
      endcase
   end

   assign front_stall  = ex_hold | haz;
   assign pc_write     = !front_stall;
   assign if_id_write  = !front_stall;
   assign id_ex_bubble = haz && !ex_hold;
   // A stalled branch is re-evaluated next cycle, so its flush waits too.
   assign if_id_flush  = id_branch && br_taken && !front_stall;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= ST_RUN;
         cnt       <= '0;
         stall_cnt <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (front_stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench: expected outputs queued per driven cycle, compared on the falling edge.
module tb_hazard_stall_ctrl;

   localparam int MUL_CYCLES = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  if_id_rs, if_id_rt, id_ex_dst, ex_mem_dst;
   logic        if_id_use_rt, id_branch, br_taken;
   logic        id_ex_regwrite, id_ex_memread, ex_mem_memread, ex_multi_start;
   logic        pc_write, if_id_write, id_ex_bubble, if_id_flush, ex_hold, multi_done;
   logic [15:0] stall_cnt;

   int n_cmp = 0;
   int n_err = 0;

   logic [21:0] exp_q[$];
   string       tag_q[$];

   // reference model state
   logic m_multi;
   int   m_cnt;
   int   m_stat;

   hazard_stall_ctrl #(.MUL_CYCLES(MUL_CYCLES), .CNT_W(8), .STAT_W(16)) dut (
      .clk(clk), .rst(rst),
      .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_use_rt(if_id_use_rt),
      .id_branch(id_branch), .br_taken(br_taken),
      .id_ex_dst(id_ex_dst), .id_ex_regwrite(id_ex_regwrite), .id_ex_memread(id_ex_memread),
      .ex_mem_dst(ex_mem_dst), .ex_mem_memread(ex_mem_memread),
      .ex_multi_start(ex_multi_start),
      .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_bubble(id_ex_bubble),
      .if_id_flush(if_id_flush), .ex_hold(ex_hold), .multi_done(multi_done),
      .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic m_match(input logic [4:0] d);
      return (d != 5'd0) && ((d == if_id_rs) || (if_id_use_rt && (d == if_id_rt)));
   endfunction

   always @(negedge clk) begin
      if (exp_q.size() > 0)
         chk(tag_q.pop_front(),
             {10'd0, pc_write, if_id_write, id_ex_bubble, if_id_flush, ex_hold, multi_done, stall_cnt},
             {10'd0, exp_q.pop_front()});
   end

   // One clock: predict outputs for current inputs, optionally queue them, then advance the model.
   task automatic cycle(input string tag, input bit check = 1'b1);
      logic haz, hold, done, fs;
      haz = (!id_ex_memread && m_match(id_ex_dst))
          || (id_branch && !id_ex_regwrite && m_match(id_ex_dst))
          || (id_branch && !ex_mem_memread && m_match(ex_mem_dst));
      hold = m_multi ? (m_cnt != 0) : ex_multi_start;
      done = m_multi && (m_cnt == 0);
      fs   = hold || haz;
      if (check) begin
         exp_q.push_back({!fs, !fs, haz && !hold, id_branch && br_taken && !fs, hold, done, 16'(m_stat)});
         tag_q.push_back(tag);
      end
      @(posedge clk);
      if (!rst) begin
         m_multi = 1'b0; m_cnt = 0; m_stat = 0;
      end else begin
         if (fs && m_stat != 65535) m_stat++;
         if (!m_multi) begin
            if (ex_multi_start) begin m_multi = 1'b1; m_cnt = MUL_CYCLES - 2; end
         end else if (m_cnt != 0) m_cnt--;
         else m_multi = 1'b0;
      end
      #1;
   endtask

   task automatic idle_inputs();
      if_id_rs = 5'd0; if_id_rt = 5'd0; if_id_use_rt = 1'b0;
      id_branch = 1'b0; br_taken = 1'b0;
      id_ex_dst = 5'd0; id_ex_regwrite = 1'b1; id_ex_memread = 1'b1;
      ex_mem_dst = 5'd0; ex_mem_memread = 1'b1; ex_multi_start = 1'b0;
   endtask

   task automatic set_load_use();
      id_ex_memread = 1'b0; id_ex_dst = 5'd5; if_id_rs = 5'd5;
   endtask

   task automatic do_reset();
      rst = 1'b0; idle_inputs();
      cycle("reset");
      rst = 1'b1;
   endtask

   initial begin
      m_multi = 1'b0; m_cnt = 0; m_stat = 0;
      rst = 1'b0; idle_inputs();
      #1;
      cycle("pre", 1'b0);
      cycle("pre", 1'b0);
      cycle("reset_state");
      rst = 1'b1;
      cycle("idle");

      set_load_use();
      cycle("load_use");
      idle_inputs();
      cycle("after_load_use");
      chk("load_use_cnt", {16'd0, stall_cnt}, 32'd1);

      id_ex_memread = 1'b0;
      cycle("zero_reg");
      idle_inputs();

      id_branch = 1'b1; br_taken = 1'b1; id_ex_regwrite = 1'b0;
      id_ex_dst = 5'd8; if_id_rt = 5'd8; if_id_use_rt = 1'b1;
      cycle("br_after_alu");
      id_ex_regwrite = 1'b1;
      cycle("br_flush");
      id_branch = 1'b0; br_taken = 1'b0;
      ex_mem_memread = 1'b0; ex_mem_dst = 5'd8; id_branch = 1'b1;
      cycle("br_ld_mem");
      idle_inputs();

      do_reset();
      ex_multi_start = 1'b1;
      cycle("mul_start");
      ex_multi_start = 1'b0;
      for (int i = 0; i < 4; i++) cycle($sformatf("mul_%0d", i));
      chk("mul_stall_cnt", {16'd0, stall_cnt}, 32'd3);

      ex_multi_start = 1'b1;
      cycle("mul2_start");
      set_load_use();
      ex_multi_start = 1'b1;
      for (int i = 0; i < 4; i++) cycle($sformatf("mul_lu_%0d", i));
      idle_inputs();

      ex_multi_start = 1'b1;
      cycle("mul3_start");
      ex_multi_start = 1'b0;
      cycle("mul3_1");
      rst = 1'b0;
      cycle("mid_multi_reset");
      rst = 1'b1;
      cycle("post_reset_0");
      cycle("post_reset_1");

      for (int i = 0; i < 300; i++) begin
         if_id_rs = 5'($urandom_range(0, 3)); if_id_rt = 5'($urandom_range(0, 3));
         if_id_use_rt = 1'($urandom); id_branch = 1'($urandom); br_taken = 1'($urandom);
         id_ex_dst = 5'($urandom_range(0, 3)); id_ex_regwrite = 1'($urandom);
         id_ex_memread = 1'($urandom); ex_mem_dst = 5'($urandom_range(0, 3));
         ex_mem_memread = 1'($urandom); ex_multi_start = ($urandom_range(0, 7) == 0);
         rst = ($urandom_range(0, 63) != 0);
         cycle("random");
      end
      rst = 1'b1;

      do_reset();
      set_load_use();
      for (int i = 0; i < 65540; i++) cycle("saturate");
      idle_inputs();
      cycle("sat_idle");
      chk("sat_value", {16'd0, stall_cnt}, 32'h0000FFFF);

      @(negedge clk);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Pipeline hazard/stall controller for the 5-stage core; the stalling counterpart to the forwarding unit. Resolves the hazards forwarding cannot: load-use, ID-stage branch operands not yet forwardable, and multi-cycle mul/div occupancy in EX. Drives PC/IF-ID write enables, ID/EX bubble insertion, IF/ID flush and EX hold. Keeps a saturating stall-cycle counter for performance debug.

Parameters:
MUL_CYCLES, 4, total EX occupancy of a mul/div op in cycles (legal range 2..255)
CNT_W, 8, width of internal occupancy counter (must hold MUL_CYCLES-1)
STAT_W, 16, width of stall statistics counter

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-low reset
if_id_rs  in  5  rs of instruction in ID
if_id_rt  in  5  rt of instruction in ID
if_id_use_rt  in  1  1 = ID instruction reads rt (R-type, store, beq/bne)
id_branch  in  1  1 = ID instruction is a branch resolved in ID
br_taken  in  1  1 = ID branch comparator says taken
id_ex_dst  in  5  destination register in EX
id_ex_regwrite  in  1  register write enable in EX, active-low (0 = writes)
id_ex_memread  in  1  load in EX, active-low (0 = load)
ex_mem_dst  in  5  destination register in MEM
ex_mem_memread  in  1  load in MEM, active-low (0 = load)
ex_multi_start  in  1  1 = mul/div entering EX this cycle
pc_write  out  1  1 = PC may update
if_id_write  out  1  1 = IF/ID may update
id_ex_bubble  out  1  1 = load NOP controls into ID/EX
if_id_flush  out  1  1 = clear IF/ID (squash fetched instr)
ex_hold  out  1  1 = hold ID/EX and EX/MEM inputs of multi-cycle unit
multi_done  out  1  1-cycle pulse on final mul/div EX cycle
stall_cnt  out  STAT_W  saturating count of stalled cycles

Behaviour:
- Match on register 0 never counts; all control inputs above are active-low where stated, matching existing regwrite polarity.
- match(d) = d!=0 && (d==if_id_rs || (if_id_use_rt && d==if_id_rt)).
- load_use = (id_ex_memread==0) && match(id_ex_dst).
- br_ex = id_branch && (id_ex_regwrite==0) && match(id_ex_dst).
- br_ld_mem = id_branch && (ex_mem_memread==0) && match(ex_mem_dst).
- haz = load_use | br_ex | br_ld_mem (combinational, same cycle).
- FSM states: RUN, MULTI. Registered state, cnt[CNT_W], stall_cnt.
- RUN: ex_multi_start=1 -> next MULTI, cnt<=MUL_CYCLES-2; else stay.
- MULTI: cnt!=0 -> cnt<=cnt-1; cnt==0 -> multi_done=1, next RUN.
- ex_hold = (state==MULTI && cnt!=0) || (state==RUN && ex_multi_start); total EX occupancy exactly MUL_CYCLES cycles including the start cycle; multi_done asserted in last of those cycles, ex_hold low in that cycle.
- front_stall = ex_hold | haz.
- pc_write = if_id_write = !front_stall.
- id_ex_bubble = haz && !ex_hold (during ex_hold ID/EX is frozen, no bubble).
- if_id_flush = id_branch && br_taken && !front_stall; stall beats flush, branch re-evaluated next cycle.
- ex_multi_start while in MULTI is ignored (cannot occur legally; no restart).
- stall_cnt: +1 every cycle front_stall=1; saturates at all-ones, never wraps.
- Outputs purely combinational from inputs+state; latency 0 cycles from hazard to stall.
- Reset (rst==0 at clk edge): state RUN, cnt 0, stall_cnt 0; reset dominates all inputs, mid-MULTI reset aborts to RUN with no multi_done pulse. During reset cycle outputs reflect RUN state: pc_write=1, if_id_write=1, id_ex_bubble=0, if_id_flush=0, ex_hold=0, multi_done=0 when hazard inputs are 0.

Decomposition:
- Shared package/header: FSM state encodings (ST_RUN, ST_MULTI), REG_ZERO=5'd0, active-low control constants (CTL_ON=1'b0).
- One natural sub-module: hazard_match (pure combinational dst-vs-rs/rt comparator with zero-register exclusion), instantiated three times.

Test Plan:
- Load-use: id_ex_memread=0, id_ex_dst=5, if_id_rs=5 -> pc_write=0, if_id_write=0, id_ex_bubble=1 one cycle; stall_cnt 0->1.
- Zero reg: id_ex_memread=0, id_ex_dst=0, if_id_rs=0 -> no stall, bubble=0.
- Branch after ALU: id_branch=1, id_ex_regwrite=0, id_ex_dst=8, if_id_rt=8, if_id_use_rt=1, br_taken=1 -> stall, if_id_flush=0; next cycle no hazard -> if_id_flush=1, pc_write=1.
- Mul occupancy, MUL_CYCLES=4: ex_multi_start pulse -> ex_hold=1 for 3 cycles, multi_done=1 on 4th, then RUN; stall_cnt=3.
- Load-use during MULTI: ex_hold=1 and haz=1 -> id_ex_bubble=0, pc_write=0.
- Reset mid-MULTI after 1 cycle: rst=0 -> next cycle RUN, ex_hold=0, stall_cnt=0, no multi_done; saturation: force 65535 stalls -> stall_cnt stays 16'hFFFF.
